// File: rtl/seg_pipe_incdec.sv
// rtl/seg_pipe_incdec.sv - pipelined incrementer/decrementer, one SEG-bit carry segment per stage
// Optional saturating mode: define SEG_PIPE_INCDEC_SAT_EN.
module seg_pipe_incdec #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic         C_IN,
  input  logic         DEC,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] SUM,
  output logic         C_OUT
);

  localparam int STAGES = N / SEG;

  generate
    if ((SEG < 1) || (SEG > N) || ((N % SEG) != 0)) begin : g_bad_param
      $error("seg_pipe_incdec: N must be a positive multiple of SEG");
    end
  endgenerate

  // Index 0 holds the raw captured operand; index k has segments 0..k-1
  // resolved. Index STAGES is the output register.
  logic [STAGES:0][N-1:0] a_q;
  logic [STAGES:0]        c_q;
  logic [STAGES:0]        vld_q;
  logic [STAGES-1:0]      dec_q;

  logic [STAGES-1:0][N-1:0] a_d;
  logic [STAGES-1:0]        c_d;
  logic                     adv;

  assign adv       = !vld_q[STAGES] || OUT_READY;
  assign IN_READY  = adv;
  assign OUT_VALID = vld_q[STAGES];
  assign SUM       = a_q[STAGES];
  assign C_OUT     = c_q[STAGES];

  always_comb begin
    logic cc;
    a_d = '0;
    c_d = '0;
    cc  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      cc     = c_q[k];
      for (int j = 0; j < SEG; j++) begin
        a_d[k][k*SEG+j] = a_q[k][k*SEG+j] ^ cc;
        cc = (dec_q[k] ? ~a_q[k][k*SEG+j] : a_q[k][k*SEG+j]) & cc;
      end
      c_d[k] = cc;
`ifdef SEG_PIPE_INCDEC_SAT_EN
      // Clamp instead of wrapping; C_OUT still flags the saturation.
      if ((k == STAGES - 1) && cc) begin
        a_d[k] = dec_q[k] ? {N{1'b0}} : {N{1'b1}};
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q   <= '0;
      c_q   <= '0;
      vld_q <= '0;
      dec_q <= '0;
    end else if (adv) begin
      a_q[0]   <= A;
      c_q[0]   <= C_IN;
      dec_q[0] <= DEC;
      vld_q[0] <= IN_VALID;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k+1]   <= a_d[k];
        c_q[k+1]   <= c_d[k];
        vld_q[k+1] <= vld_q[k];
        if (k + 1 < STAGES) begin
          dec_q[k+1] <= dec_q[k];
        end
      end
    end
  end

endmodule

// File: doc/seg_pipe_incdec.md
Name: seg_pipe_incdec

Overview:
- Pipelined, parametrised incrementer/decrementer: SUM = A + C_IN or A − C_IN (mod 2^N).
- Carry/borrow ripples through one SEG-bit segment per clock, so the wide chain never sits in a single combinational path.
- Valid/ready handshake on both sides, one result per cycle when not stalled.
- Used as the counter/address-advance primitive wherever an N-bit ripple chain would limit timing.

Parameters:
- N, 16, operand/result width in bits; must be an integer multiple of SEG.
- SEG, 4, segment width resolved per pipeline stage; 1 ≤ SEG ≤ N.
- STAGES (localparam), N/SEG, pipeline depth and latency in cycles.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  A, C_IN and DEC are valid this cycle.
- IN_READY  output  1  block accepts input this cycle.
- A  input  N  operand.
- C_IN  input  1  increment/decrement amount (0 or 1).
- DEC  input  1  0 = add C_IN, 1 = subtract C_IN.
- OUT_VALID  output  1  SUM and C_OUT are valid.
- OUT_READY  input  1  downstream accepts the result.
- SUM  output  N  result.
- C_OUT  output  1  final carry-out (inc) or borrow-out (dec) from bit N−1.

Behaviour:
- Reset (RST=1 at a clock edge): all stage valid bits, SUM, C_OUT and OUT_VALID go to 0. Internal data registers also clear to 0. In-flight items are discarded. IN_READY=1 in the cycle after reset.
- Global advance: adv = !OUT_VALID || OUT_READY. IN_READY = adv, combinational. When adv=0 every stage holds, including bubbles.
- Accept: the input is taken on an edge with IN_VALID && IN_READY.
- Stage 1 captures A, DEC and the seed c = C_IN.
- Stage k (1..STAGES) resolves bits [k·SEG−1:(k−1)·SEG]:
  - Inc: s_i = a_i ^ c; c_next = a_i & c.
  - Dec: s_i = a_i ^ c; c_next = ~a_i & c.
  - Lower resolved bits, unresolved upper A bits, DEC and the segment carry pass to the next stage unchanged.
- Stage valid bits shift with adv. A bubble enters when no input is accepted.
- Latency: an item accepted at edge t appears with OUT_VALID=1 after edge t+STAGES (no stall). Each cycle of adv=0 adds one cycle.
- Throughput is 1 item per cycle while OUT_READY=1. Ordering is strictly FIFO.
- Output hold: while OUT_VALID=1 and OUT_READY=0, SUM and C_OUT hold stable. Once asserted, OUT_VALID stays high until the handshake completes.
- OUT_VALID=0 and OUT_READY=1 with no valid item: the pipeline advances and bubbles collapse.
- Arithmetic boundaries:
  - C_IN=0 → SUM=A, C_OUT=0.
  - Inc of all-ones → SUM=0, C_OUT=1 (wrap).
  - Dec of 0 with C_IN=1 → SUM=all-ones, C_OUT=1 (wrap).
- SEG=N → STAGES=1, latency 1.
- N % SEG ≠ 0 is illegal: elaboration must fail via a generate-time error.
- Simultaneous accept and output handshake in the same cycle is legal and required for full throughput.
- RST asserted mid-stream overrides all handshakes in that cycle.

Optional Feature:
- Macro: SEG_PIPE_INCDEC_SAT_EN.
- Defined: saturating mode. When the final carry/borrow is 1, SUM is forced to all-ones (DEC=0) or all-zeros (DEC=1). C_OUT still reports 1 as a saturation flag. The override is applied in the last stage, so latency is unchanged.
- Undefined: modular wrap as above.

Test Plan:
- N=16, SEG=4. After reset, A=0x00FF, C_IN=1, DEC=0, OUT_READY=1 → 4 cycles later SUM=0x0100, C_OUT=0.
- A=0xFFFF, C_IN=1, DEC=0 → SUM=0x0000, C_OUT=1. With SAT_EN defined → SUM=0xFFFF, C_OUT=1.
- A=0x0000, C_IN=1, DEC=1 → SUM=0xFFFF, C_OUT=1. With SAT_EN defined → SUM=0x0000, C_OUT=1. Also A=0x1000, DEC=1 → SUM=0x0FFF, C_OUT=0.
- Back-to-back 8 inputs A=0..7, C_IN=1, OUT_READY=1 → outputs 1..8 on consecutive cycles, no bubbles, IN_READY constantly 1.
- Stall: hold OUT_READY=0 for 5 cycles with a full pipeline → SUM/C_OUT frozen, IN_READY=0. On release, the remaining results arrive in order with none lost or duplicated.
- Reset mid-stream with 3 items in flight → OUT_VALID=0, SUM=0 after the reset edge. None of the flushed items ever appear on the output.
